fpu_unpack_norm: RTL
====================

# fpu_unpack_norm

Operand front end for the FPU that sits directly upstream of the classifier and the arithmetic stages. It accepts one IEEE-754 binary32 operand through a valid/ready handshake and unpacks it into sign, unbiased exponent and a significand with an explicit hidden bit. Subnormals are normalized iteratively, one left shift per cycle. The result is a one-hot class word using the FPU class encoding, plus the raw operand for pass-through.

## Interface
- Parameters: none (binary32 only).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of any in-flight operand
- in_valid  in  1  operand present
- in_ready  out  1  operand accepted when in_valid && in_ready at a rising edge
- in_data  in  32  binary32 operand
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result when out_valid && out_ready
- out_sign  out  1  in_data[31]
- out_exp  out  10  unbiased exponent, two's complement
- out_sig  out  24  significand; bit 23 is the explicit integer bit
- out_class  out  32  one-hot class; bits 31:10 always 0
- out_raw  out  32  copy of the accepted in_data

## Operation
- Fields: s = in_data[31]; E = in_data[30:23]; F = in_data[22:0].
- Class bits:
  - bit0: −inf
  - bit1: −normal
  - bit2: −subnormal
  - bit3: −zero
  - bit4: +zero
  - bit5: +subnormal
  - bit6: +normal
  - bit7: +inf
  - bit8: sNaN (E=FF, F≠0, F[22]=0)
  - bit9: qNaN (E=FF, F[22]=1)
  - NaN classes ignore the sign.
- Unpack rules:
  - Normal: exp = E−127; sig = {1,F}.
  - Zero: exp = 0; sig = 0.
  - Inf/NaN: exp = +128; sig = {0,F}.
  - Subnormal: start with exp = −126 and sig = {0,F}, then normalize.
- FSM states are IDLE, NORM and HOLD.
  - **IDLE:** in_ready=1; out_valid=0. On accept, a subnormal goes to NORM; all other classes go to HOLD with the final result registered.
  - **NORM:** in_ready=0; out_valid=0. Each cycle: sig <<= 1, exp −= 1. When the shifted sig has bit 23 set, go to HOLD. For a leading one at F[k], there are 23−k NORM cycles and the final exp = k−149 (range −149..−127).
  - **HOLD:** out_valid=1. in_ready = out_ready.
    - out_ready=1 with no accept: go to IDLE.
    - out_ready=1 with an accept in the same cycle: go to NORM or HOLD for the new operand, with no bubble.
    - out_ready=0: all outputs hold stable.
- out_class and out_raw are registered at accept and held until the next accept.
- flush: at the next edge, go to IDLE and clear out_valid. flush has priority over accept and over completion. While flush=1, in_ready is forced to 0.

## Timing
- Reset (async assert, sync release by the system):
  - state = IDLE
  - out_valid = 0; in_ready = 1 (while not flushing)
  - out_sign, out_exp, out_sig, out_class, out_raw = 0
- Latency from the accept edge to out_valid high:
  - Normal, zero, inf, NaN: 1 cycle.
  - Subnormal with leading one at F[k]: 24−k cycles (2 to 24).
- Throughput with out_ready held at 1: one non-subnormal operand per cycle.
- All outputs are registered; there is no combinational in_data→out path. in_ready depends combinationally on out_ready in HOLD only.
- Reset asserted mid-NORM or mid-HOLD discards the operand immediately; no partial result is ever presented.
- out_exp arithmetic is 10-bit signed; no wrap is possible within −149..+128.

## Test plan
- **Reset and idle:** assert rst_n=0 mid-stream, then release.
  - Required: all outputs 0, in_ready=1, out_valid=0.
- **Normal operand:** in_data=0x3F800000.
  - Required: out_valid 1 cycle later with sign 0, exp 0x000, sig 0x800000, class 0x040.
  - Also send 0xC0400000. Required: sign 1, exp 0x001, sig 0xC00000, class 0x002.
- **Subnormal normalization:** in_data=0x00000001.
  - Required: out_valid exactly 24 cycles after accept, exp 0x36B (−149), sig 0x800000, class 0x020.
  - Also send 0x80400000. Required: 2 cycles, exp −127 (0x381), class 0x004.
- **Specials:**
  - 0xFF800000 → class 0x001, exp 0x080.
  - 0x7FC00000 → class 0x200.
  - 0x7F800001 → class 0x100.
  - 0x80000000 → class 0x008, exp 0, sig 0.
- **Backpressure:** hold out_ready=0 for 5 cycles with a second operand waiting.
  - Required: outputs stable and in_ready=0 throughout.
  - Then raise out_ready=1. Required: the second operand is accepted in that same cycle, and its result appears the next cycle.
- **Kill mid-normalize:** accept 0x80000001, then pulse flush 5 cycles later.
  - Required: out_valid never asserts for it; IDLE with in_ready=1 the following cycle.
  - Repeat using rst_n instead of flush. Required: identical outcome.

Source files
------------

// File: rtl/fpu_unpack_norm_if.sv
// Operand-in / unpacked-result-out handshake bundle for the FPU operand front end.
// The slave side is the unpacker; the master side is the surrounding pipeline.
interface fpu_unpack_norm_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [9:0]  out_exp;
    logic [23:0] out_sig;
    logic [31:0] out_class;
    logic [31:0] out_raw;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_sig, out_class, out_raw
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_sig, out_class, out_raw
    );
endinterface

// File: rtl/fpu_unpack_norm.sv
// binary32 operand unpack into sign / unbiased exponent / explicit-bit significand,
// with subnormals normalized one left shift per cycle, plus one-hot class and raw copy.
//   state | meaning
//   IDLE  | no result held, ready for an operand
//   NORM  | shifting a subnormal significand left, one bit per cycle
//   HOLD  | result valid, waiting for the consumer
module fpu_unpack_norm (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    fpu_unpack_norm_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic        sign_q, sign_d;
    logic [9:0]  exp_q, exp_d;
    logic [23:0] sig_q, sig_d;
    logic [31:0] class_q, class_d;
    logic [31:0] raw_q, raw_d;

    logic        in_sign;
    logic [7:0]  in_e;
    logic [22:0] in_f;
    logic        e_zero, e_max, f_zero;
    logic        in_sub;
    logic [9:0]  in_exp;
    logic [23:0] in_sig;
    logic [31:0] in_class;
    logic        accept;

    assign in_sign = bus.in_data[31];
    assign in_e    = bus.in_data[30:23];
    assign in_f    = bus.in_data[22:0];
    assign e_zero  = (in_e == 8'h00);
    assign e_max   = (in_e == 8'hFF);
    assign f_zero  = (in_f == 23'd0);
    assign accept  = bus.in_valid && bus.in_ready;

    always_comb begin
        in_sub   = 1'b0;
        in_exp   = 10'd0;
        in_sig   = 24'd0;
        in_class = 32'd0;
        if (e_max) begin
            in_exp = 10'd128;
            in_sig = {1'b0, in_f};
            if (f_zero)
                in_class = in_sign ? 32'h0000_0001 : 32'h0000_0080;
            else if (in_f[22])
                in_class = 32'h0000_0200;
            else
                in_class = 32'h0000_0100;
        end else if (e_zero) begin
            if (f_zero) begin
                in_class = in_sign ? 32'h0000_0008 : 32'h0000_0010;
            end else begin
                // -126 in 10-bit two's complement; NORM walks it down from here
                in_sub   = 1'b1;
                in_exp   = 10'h382;
                in_sig   = {1'b0, in_f};
                in_class = in_sign ? 32'h0000_0004 : 32'h0000_0020;
            end
        end else begin
            in_exp   = {2'b00, in_e} - 10'd127;
            in_sig   = {1'b1, in_f};
            in_class = in_sign ? 32'h0000_0002 : 32'h0000_0040;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            sign_q      <= 1'b0;
            exp_q       <= 10'd0;
            sig_q       <= 24'd0;
            class_q     <= 32'd0;
            raw_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            sig_q       <= sig_d;
            class_q     <= class_d;
            raw_q       <= raw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) state_d = in_sub ? NORM : HOLD;
                // bit 22 set now means bit 23 is set after this cycle's shift
                NORM: if (sig_q[22]) state_d = HOLD;
                HOLD: begin
                    if (accept)
                        state_d = in_sub ? NORM : HOLD;
                    else if (bus.out_ready)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sign_d  = sign_q;
        exp_d   = exp_q;
        sig_d   = sig_q;
        class_d = class_q;
        raw_d   = raw_q;
        if (accept) begin
            sign_d  = in_sign;
            exp_d   = in_exp;
            sig_d   = in_sig;
            class_d = in_class;
            raw_d   = bus.in_data;
        end else if (state_q == NORM && !flush) begin
            sig_d = {sig_q[22:0], 1'b0};
            exp_d = exp_q - 10'd1;
        end
        out_valid_d = (state_d == HOLD);
    end

    always_comb begin
        bus.in_ready = 1'b0;
        if (!flush) begin
            case (state_q)
                IDLE:    bus.in_ready = 1'b1;
                HOLD:    bus.in_ready = bus.out_ready;
                default: bus.in_ready = 1'b0;
            endcase
        end
        bus.out_valid = out_valid_q;
        bus.out_sign  = sign_q;
        bus.out_exp   = exp_q;
        bus.out_sig   = sig_q;
        bus.out_class = class_q;
        bus.out_raw   = raw_q;
    end
endmodule
